// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Generates the fetch address for a simple in-order core. The default step
//   is pc+4. Jumps, taken branches and returns from an interrupt handler
//   redirect it. Halt freezes it. An optional single-level interrupt scheme
//   saves the return address in epc and vectors the fetch to TRAP_VECTOR.
//
// Build option:
//   PC_SEQ_IRQ_EN  - when defined, compiles in interrupt support: irq, eret,
//                    epc, irq_ack, the TRAP state and trap exit from HALT.
//                    When undefined, the ports stay in place, irq and eret
//                    are ignored, epc and irq_ack read 0, and HALT is left
//                    only by reset.
//
// Parameters:
//   RESET_VECTOR   - pc value after reset
//   TRAP_VECTOR    - pc value on interrupt entry
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   stall          in   1   hold every register this cycle, no redirects
//   branch_taken   in   1   redirect to branch_target
//   branch_target  in   32  branch destination (bits [1:0] ignored)
//   jump           in   1   redirect to jump_target
//   jump_target    in   32  jump destination (bits [1:0] ignored)
//   eret           in   1   return from handler, pc <= epc
//   irq            in   1   level-sensitive interrupt request
//   halt           in   1   enter HALT
//   pc             out  32  current fetch address
//   epc            out  32  saved return address
//   irq_ack        out  1   high during the single TRAP cycle
//   state          out  2   0 RUN, 1 TRAP, 2 HALT
// ---------------------------------------------------------------------------
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal fetch: pc+4 or a redirect
// TRAP  | one-cycle interrupt entry, pc = TRAP_VECTOR, irq_ack high
// HALT  | pc frozen; left by reset or by interrupt entry
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        eret,
    input  logic        irq,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        irq_ack,
    output logic [1:0]  state
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_TRAP = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] epc_q;
    logic [31:0] epc_d;
    logic        ie_q;
    logic        ie_d;

    logic [31:0] pc_seq;
    logic [31:0] run_target;
    logic        trap_entry;
    logic        eret_en;

    assign pc_seq = pc_q + 32'd4;

`ifdef PC_SEQ_IRQ_EN
    // Trap entry is only possible from RUN or HALT; ie is already clear
    // while in TRAP, so the state check only guards the unused encoding.
    assign trap_entry = irq && ie_q && !stall &&
                        ((state_q == ST_RUN) || (state_q == ST_HALT));
    assign eret_en    = eret;
`else
    assign trap_entry = 1'b0;
    assign eret_en    = 1'b0;

    logic unused_irq_path;
    assign unused_irq_path = irq ^ eret ^ ie_q;
`endif

    // Redirect-resolved next pc in RUN, ignoring trap entry and halt. This
    // is also the return address captured when an interrupt is taken.
    always_comb begin
        run_target = pc_seq;
        if (eret_en) begin
            run_target = epc_q;
        end else if (jump) begin
            run_target = {jump_target[31:2], 2'b00};
        end else if (branch_taken) begin
            run_target = {branch_target[31:2], 2'b00};
        end
    end

    // State and architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            epc_q   <= 32'd0;
            ie_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ie_q    <= ie_d;
        end
    end

    // Next-state and next-pc logic. A stall leaves every default in place.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        ie_d    = ie_q;
        if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (trap_entry) begin
                        epc_d   = {run_target[31:2], 2'b00};
                        pc_d    = TRAP_VECTOR;
                        ie_d    = 1'b0;
                        state_d = ST_TRAP;
                    end else if (halt) begin
                        // Halt freezes pc and overrides any redirect,
                        // including eret, which then leaves ie untouched.
                        state_d = ST_HALT;
                    end else begin
                        pc_d = run_target;
                        if (eret_en) begin
                            ie_d = 1'b1;
                        end
                    end
                end
                ST_TRAP: begin
                    pc_d    = pc_seq;
                    state_d = ST_RUN;
                end
                ST_HALT: begin
                    if (trap_entry) begin
                        epc_d   = {pc_q[31:2], 2'b00};
                        pc_d    = TRAP_VECTOR;
                        ie_d    = 1'b0;
                        state_d = ST_TRAP;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Outputs. irq_ack is masked by stall so a stalled TRAP cycle does not
    // acknowledge twice.
    always_comb begin
        irq_ack = (state_q == ST_TRAP) && !stall;
        pc      = pc_q;
        epc     = epc_q;
        state   = state_q;
    end

endmodule
